// File: rtl/rollcall_pkg.sv
// Shared definitions for the rollcall_scan block: FSM state encoding and
// default symbol width / ring depth.
package rollcall_pkg;

  localparam int DEF_W = 2;
  localparam int DEF_N = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_SCAN   = 2'd2,
    ST_REPORT = 2'd3
  } state_t;

endpackage

// File: rtl/rollcall_pair_cmp.sv
// Combinational pair comparator: derives the successor symbol of the pattern
// head and flags whether (sym_a, sym_b) equals (pat, succ).
module rollcall_pair_cmp #(
  parameter int W = 2
) (
  input  logic [W-1:0] pat,
  input  logic         mode,
  input  logic [W-1:0] sym_a,
  input  logic [W-1:0] sym_b,
  output logic [W-1:0] succ,
  output logic         hit
);

  // Successor wraps modulo 2^W naturally through W-bit arithmetic.
  always_comb begin
    if (mode) begin
      succ = pat - W'(1'b1);
    end else begin
      succ = pat + W'(1'b1);
    end
    hit = (sym_a == pat) && (sym_b == succ);
  end

endmodule

// File: rtl/rollcall_scan.sv
// Roll-call scanner: loads N symbols into a ring, checks one adjacent pair per
// cycle against (pat, succ) and reports the hit vector with summary fields.
module rollcall_scan
  import rollcall_pkg::*;
#(
  parameter int W = DEF_W,
  parameter int N = DEF_N
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [W-1:0]           pat,
  input  logic                   mode,
  input  logic                   abort,
  input  logic                   in_valid,
  input  logic [W-1:0]           in_sym,
  output logic                   in_ready,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [N-1:0]           match,
  output logic                   any,
  output logic                   par,
  output logic [$clog2(N)-1:0]   first,
  output logic [$clog2(N):0]     count,
  output logic [W-1:0]           y,
  output logic                   busy
);

  localparam int IW = $clog2(N);
  localparam int CW = IW + 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  function automatic logic [CW-1:0] pop_count(input logic [N-1:0] m);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < N; i++) c = c + CW'(m[i]);
    return c;
  endfunction

  function automatic logic [IW-1:0] low_index(input logic [N-1:0] m);
    logic [IW-1:0] f;
    f = '0;
    for (int i = N - 1; i >= 0; i--) f = m[i] ? IW'(i) : f;
    return f;
  endfunction

  state_t          state_q, state_d;
  logic [W-1:0]    pat_q, pat_d;
  logic            mode_q, mode_d;
  logic [IW-1:0]   load_idx_q, load_idx_d;
  logic [IW-1:0]   scan_idx_q, scan_idx_d;
  logic [N-1:0]    match_q, match_d;
  logic [W-1:0]    ring_q [N];
  logic [W-1:0]    ring_d [N];
  logic [N-1:0]    res_match_q, res_match_d;
  logic            res_any_q, res_any_d;
  logic            res_par_q, res_par_d;
  logic [IW-1:0]   res_first_q, res_first_d;
  logic [CW-1:0]   res_count_q, res_count_d;
  logic [W-1:0]    res_y_q, res_y_d;
  logic [IW-1:0]   scan_nxt_s;
  logic [W-1:0]    succ_s;
  logic            hit_s;

  assign scan_nxt_s = scan_idx_q + IW'(1'b1);

  // Single comparator, time-shared: pair i is (ring[i], ring[i+1 mod N]).
  rollcall_pair_cmp #(.W(W)) u_pair_cmp (
    .pat   (pat_q),
    .mode  (mode_q),
    .sym_a (ring_q[scan_idx_q]),
    .sym_b (ring_q[scan_nxt_s]),
    .succ  (succ_s),
    .hit   (hit_s)
  );

  // Next-state and datapath updates; abort overrides every other input.
  always_comb begin
    state_d     = state_q;
    pat_d       = pat_q;
    mode_d      = mode_q;
    load_idx_d  = load_idx_q;
    scan_idx_d  = scan_idx_q;
    match_d     = match_q;
    ring_d      = ring_q;
    res_match_d = res_match_q;
    res_any_d   = res_any_q;
    res_par_d   = res_par_q;
    res_first_d = res_first_q;
    res_count_d = res_count_q;
    res_y_d     = res_y_q;
    if (abort) begin
      state_d     = ST_IDLE;
      load_idx_d  = '0;
      scan_idx_d  = '0;
      match_d     = '0;
      res_match_d = '0;
      res_any_d   = 1'b0;
      res_par_d   = 1'b0;
      res_first_d = '0;
      res_count_d = '0;
      res_y_d     = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            pat_d      = pat;
            mode_d     = mode;
            load_idx_d = '0;
            scan_idx_d = '0;
            match_d    = '0;
            state_d    = ST_LOAD;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_LOAD: begin
          if (in_valid) begin
            ring_d[load_idx_q] = in_sym;
            load_idx_d         = load_idx_q + IW'(1'b1);
            state_d            = (load_idx_q == LAST_IDX) ? ST_SCAN : ST_LOAD;
          end else begin
            state_d = ST_LOAD;
          end
        end
        ST_SCAN: begin
          match_d[scan_idx_q] = match_q[scan_idx_q] | hit_s;
          scan_idx_d          = scan_nxt_s;
          // Results are frozen into output flops as the last pair retires.
          if (scan_idx_q == LAST_IDX) begin
            state_d     = ST_REPORT;
            res_match_d = match_d;
            res_any_d   = |match_d;
            res_par_d   = ^match_d;
            res_first_d = low_index(match_d);
            res_count_d = pop_count(match_d);
            res_y_d     = (|match_d) ? succ_s : '0;
          end else begin
            state_d = ST_SCAN;
          end
        end
        ST_REPORT: begin
          if (out_ready) begin
            state_d     = ST_IDLE;
            res_match_d = '0;
            res_any_d   = 1'b0;
            res_par_d   = 1'b0;
            res_first_d = '0;
            res_count_d = '0;
            res_y_d     = '0;
          end else begin
            state_d = ST_REPORT;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      pat_q       <= '0;
      mode_q      <= 1'b0;
      load_idx_q  <= '0;
      scan_idx_q  <= '0;
      match_q     <= '0;
      ring_q      <= '{default: '0};
      res_match_q <= '0;
      res_any_q   <= 1'b0;
      res_par_q   <= 1'b0;
      res_first_q <= '0;
      res_count_q <= '0;
      res_y_q     <= '0;
    end else begin
      state_q     <= state_d;
      pat_q       <= pat_d;
      mode_q      <= mode_d;
      load_idx_q  <= load_idx_d;
      scan_idx_q  <= scan_idx_d;
      match_q     <= match_d;
      ring_q      <= ring_d;
      res_match_q <= res_match_d;
      res_any_q   <= res_any_d;
      res_par_q   <= res_par_d;
      res_first_q <= res_first_d;
      res_count_q <= res_count_d;
      res_y_q     <= res_y_d;
    end
  end

  assign in_ready  = (state_q == ST_LOAD);
  assign out_valid = (state_q == ST_REPORT);
  assign busy      = (state_q != ST_IDLE);
  assign match     = res_match_q;
  assign any       = res_any_q;
  assign par       = res_par_q;
  assign first     = res_first_q;
  assign count     = res_count_q;
  assign y         = res_y_q;

endmodule

// File: tb/tb_rollcall_scan.sv
// Self-checking bench for rollcall_scan (W=2, N=4) using a scoreboard queue of
// expected results built from an independent reference model.
module tb_rollcall_scan;

  localparam int W = 2;
  localparam int N = 4;

  typedef struct packed {
    logic [3:0] m;
    logic       any;
    logic       par;
    logic [1:0] first;
    logic [2:0] count;
    logic [1:0] y;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n, start, mode, abort, in_valid, out_ready;
  logic [1:0] pat, in_sym, y, first;
  logic       in_ready, out_valid, any, par, busy;
  logic [3:0] match;
  logic [2:0] count;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb_q[$];

  rollcall_scan #(.W(W), .N(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pat(pat), .mode(mode),
    .abort(abort), .in_valid(in_valid), .in_sym(in_sym), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .match(match), .any(any),
    .par(par), .first(first), .count(count), .y(y), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model; sv packs symbol i in bits [2i+1:2i].
  function automatic exp_t model(input logic [7:0] sv, input logic [1:0] p, input logic md);
    exp_t e;
    logic [1:0] sc, a, b;
    sc = md ? p - 2'd1 : p + 2'd1;
    e = '0;
    for (int i = 0; i < 4; i++) begin
      a = sv[2*i +: 2];
      b = sv[2*((i + 1) % 4) +: 2];
      e.m[i] = (a == p) && (b == sc);
    end
    e.any = |e.m;
    e.par = ^e.m;
    for (int i = 0; i < 4; i++) e.count = e.count + {2'b00, e.m[i]};
    for (int i = 3; i >= 0; i--) if (e.m[i]) e.first = 2'(i);
    e.y = e.any ? sc : 2'd0;
    return e;
  endfunction

  function automatic logic [12:0] outs();
    return {match, any, par, first, count, y};
  endfunction

  task automatic start_rc(input logic [1:0] p, input logic md);
    pat = p; mode = md; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; pat = ~p; mode = ~md;
  endtask

  task automatic load_syms(input logic [7:0] sv, input bit toggle);
    for (int i = 0; i < 4; i++) begin
      if (toggle) begin
        in_valid = 1'b0; in_sym = 2'($urandom_range(0, 3));
        @(posedge clk); #1;
      end
      in_valid = 1'b1; in_sym = sv[2*i +: 2];
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    exp_t e;
    int n;
    rst_n = 1'b0; start = 1'b0; pat = 2'd0; mode = 1'b0; abort = 1'b0;
    in_valid = 1'b0; in_sym = 2'd0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({busy, in_ready, out_valid, outs()} !== 16'd0) begin
      n_fail++; $display("FAIL reset_state: got %h want 0", {busy, in_ready, out_valid, outs()});
    end
    rst_n = 1'b1;
    sb_q.push_back(model({2'd0, 2'd1, 2'd3, 2'd2}, 2'd2, 1'b0));
    start_rc(2'd2, 1'b0);
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL first_start: in_ready got %b want 1", in_ready);
    end
    load_syms({2'd0, 2'd1, 2'd3, 2'd2}, 1'b0);
    n = 0;
    do begin @(negedge clk); n++; end while (out_valid !== 1'b1 && n < 40);
    n_checks++;
    if (n !== 5) begin n_fail++; $display("FAIL latency_first: got %0d want 5", n); end
    e = sb_q.pop_front();
    n_checks++;
    if (outs() !== e) begin n_fail++; $display("FAIL result_first: got %h want %h", outs(), e); end
    out_ready = 1'b1; @(posedge clk); #1; out_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({busy, out_valid, outs()} !== 15'd0) begin
      n_fail++; $display("FAIL idle_first: got %h want 0", {busy, out_valid, outs()});
    end
  endtask

  task automatic test_patterns;
    logic [7:0] sv_t [4];
    logic [1:0] p_t  [4];
    logic       m_t  [4];
    exp_t e;
    int n;
    sv_t[0] = {2'd2, 2'd3, 2'd0, 2'd1}; p_t[0] = 2'd2; m_t[0] = 1'b1;
    sv_t[1] = {2'd3, 2'd2, 2'd3, 2'd2}; p_t[1] = 2'd2; m_t[1] = 1'b0;
    sv_t[2] = {2'd3, 2'd3, 2'd3, 2'd3}; p_t[2] = 2'd2; m_t[2] = 1'b0;
    sv_t[3] = 8'($urandom);              p_t[3] = 2'($urandom); m_t[3] = 1'($urandom);
    for (int t = 0; t < 4; t++) begin
      sb_q.push_back(model(sv_t[t], p_t[t], m_t[t]));
      start_rc(p_t[t], m_t[t]);
      load_syms(sv_t[t], 1'b0);
      n = 0;
      do begin @(negedge clk); n++; end while (out_valid !== 1'b1 && n < 40);
      e = sb_q.pop_front();
      n_checks++;
      if (outs() !== e) begin n_fail++; $display("FAIL result_pat%0d: got %h want %h", t, outs(), e); end
      out_ready = 1'b1; @(posedge clk); #1; out_ready = 1'b0;
    end
  endtask

  task automatic test_wrap_stall;
    exp_t e;
    int n;
    sb_q.push_back(model({2'd3, 2'd2, 2'd1, 2'd0}, 2'd3, 1'b0));
    start_rc(2'd3, 1'b0);
    load_syms({2'd3, 2'd2, 2'd1, 2'd0}, 1'b0);
    n = 0;
    do begin @(negedge clk); n++; end while (out_valid !== 1'b1 && n < 40);
    e = sb_q.pop_front();
    for (int c = 0; c < 5; c++) begin
      n_checks++;
      if ({out_valid, outs()} !== {1'b1, e}) begin
        n_fail++; $display("FAIL stall_hold%0d: got %h want %h", c, {out_valid, outs()}, {1'b1, e});
      end
      @(negedge clk);
    end
    out_ready = 1'b1; @(posedge clk); #1; out_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({busy, out_valid, outs()} !== 15'd0) begin
      n_fail++; $display("FAIL stall_idle: got %h want 0", {busy, out_valid, outs()});
    end
  endtask

  task automatic test_toggle_start;
    exp_t e;
    int n;
    sb_q.push_back(model({2'd1, 2'd0, 2'd1, 2'd0}, 2'd0, 1'b0));
    start_rc(2'd0, 1'b0);
    out_ready = 1'b1;
    load_syms({2'd1, 2'd0, 2'd1, 2'd0}, 1'b1);
    n = 0;
    do begin
      @(negedge clk); n++;
      start    = (n == 2);
      pat      = 2'd3;
      in_valid = 1'b1;
      in_sym   = 2'd3;
    end while (out_valid !== 1'b1 && n < 40);
    start = 1'b0; in_valid = 1'b0;
    n_checks++;
    if (n !== 5) begin n_fail++; $display("FAIL latency_toggle: got %0d want 5", n); end
    e = sb_q.pop_front();
    n_checks++;
    if (outs() !== e) begin n_fail++; $display("FAIL result_toggle: got %h want %h", outs(), e); end
    @(posedge clk); #1; out_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({busy, out_valid} !== 2'b00) begin
      n_fail++; $display("FAIL toggle_idle: busy/out_valid got %b want 00", {busy, out_valid});
    end
  endtask

  task automatic test_abort;
    start_rc(2'd1, 1'b1);
    load_syms({2'd2, 2'd1, 2'd0, 2'd1}, 1'b0);
    @(negedge clk);
    @(negedge clk);
    abort = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1; abort = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({busy, out_valid, in_ready, outs()} !== 16'd0) begin
      n_fail++; $display("FAIL abort_idle: got %h want 0", {busy, out_valid, in_ready, outs()});
    end
  endtask

  task automatic test_reset_midload;
    start_rc(2'd3, 1'b1);
    in_valid = 1'b1; in_sym = 2'd3; @(posedge clk); #1;
    in_sym = 2'd2; @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n = 1'b0; #1;
    n_checks++;
    if ({busy, out_valid, in_ready, outs()} !== 16'd0) begin
      n_fail++; $display("FAIL reset_midload: got %h want 0", {busy, out_valid, in_ready, outs()});
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_back_to_back;
    logic [7:0] sv;
    logic [1:0] p;
    logic       md;
    exp_t e;
    int n;
    for (int t = 0; t < 6; t++) begin
      sv = (t == 0) ? {2'd0, 2'd1, 2'd2, 2'd3} : 8'($urandom);
      p  = (t == 0) ? 2'd3 : 2'($urandom);
      md = (t == 0) ? 1'b1 : 1'($urandom);
      sb_q.push_back(model(sv, p, md));
      start_rc(p, md);
      load_syms(sv, t[0]);
      n = 0;
      do begin @(negedge clk); n++; end while (out_valid !== 1'b1 && n < 40);
      n_checks++;
      if (n !== 5) begin n_fail++; $display("FAIL latency_b2b%0d: got %0d want 5", t, n); end
      e = sb_q.pop_front();
      n_checks++;
      if (outs() !== e) begin n_fail++; $display("FAIL result_b2b%0d: got %h want %h", t, outs(), e); end
      out_ready = 1'b1; @(posedge clk); #1; out_ready = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_patterns();
    test_wrap_stall();
    test_toggle_start();
    test_abort();
    test_back_to_back();
    test_reset_midload();
    test_back_to_back();
    n_checks++;
    if (sb_q.size() !== 0) begin
      n_fail++; $display("FAIL scoreboard_drain: %0d left want 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rollcall_scan.md
ROLLCALL_SCAN -- requirements
Module: rollcall_scan

Interface
REQ-001 Parameter W, default 2: symbol width in bits, W>=1.
REQ-002 Parameter N, default 4: ring depth in symbols, a power of two, N>=2.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 start  in  1  request a new roll-call; sampled only in IDLE.
REQ-006 pat  in  W  pattern head symbol; captured when start is accepted.
REQ-007 mode  in  1  successor direction: 0 = pat+1, 1 = pat-1 (both mod 2^W); captured with pat.
REQ-008 abort  in  1  synchronous return to IDLE from any state.
REQ-009 in_valid  in  1  in_sym is valid this cycle.
REQ-010 in_sym  in  W  ring symbol.
REQ-011 in_ready  out  1  high only in LOAD.
REQ-012 out_valid  out  1  high only in REPORT.
REQ-013 out_ready  in  1  consumer accepts the result.
REQ-014 match  out  N  bit i set when the pair (ring[i], ring[(i+1) mod N]) equals (pat, succ).
REQ-015 any  out  1  OR of match.
REQ-016 par  out  1  XOR of match.
REQ-017 first  out  clog2(N)  index of lowest set bit of match; 0 when none.
REQ-018 count  out  clog2(N)+1  number of set bits of match.
REQ-019 y  out  W  succ when any=1, else 0.
REQ-020 busy  out  1  high in any state other than IDLE.

Function
REQ-021 States IDLE, LOAD, SCAN, REPORT; single FSM.
REQ-022 IDLE: start=1 -> capture pat/mode, clear load index, scan index, match, go LOAD next cycle.
REQ-023 LOAD: symbol accepted when in_valid && in_ready, written to ring[load index], index increments; Nth accepted symbol -> SCAN next cycle.
REQ-024 SCAN: exactly one pair i per cycle, i = 0..N-1; hit sets match[i]; after i=N-1 -> REPORT; SCAN lasts N cycles.
REQ-025 Wrap-around: pair N-1 compares ring[N-1] with ring[0]; succ wraps mod 2^W (pat=2^W-1, mode 0 -> succ=0; pat=0, mode 1 -> succ=2^W-1).
REQ-026 Latency: last symbol accepted in cycle k -> out_valid high in cycle k+N+1.
REQ-027 REPORT: match/any/par/first/count/y held stable while out_valid && !out_ready; transfer on out_valid && out_ready -> IDLE next cycle.
REQ-028 start outside IDLE, in_valid outside LOAD, and out_ready outside REPORT are ignored.
REQ-029 abort has priority over every other input in the same cycle; next state IDLE, match cleared; ring contents need not be cleared.
REQ-030 Changes to pat/mode after capture have no effect on the running roll-call.
REQ-031 Result outputs are 0 whenever out_valid=0.

Reset
REQ-032 rst_n low -> state IDLE, all indices 0, match 0, in_ready=0, out_valid=0, busy=0, all result outputs 0, regardless of state (including mid-LOAD or mid-SCAN).
REQ-033 First start is accepted on the first rising edge after rst_n deasserts.

Structure
REQ-034 Package rollcall_pkg holds the state encoding and the default W and N values.
REQ-035 Sub-module rollcall_pair_cmp (combinational) computes succ from pat/mode and the hit for one pair; instanced once and time-shared across the scan.

Verification
REQ-036 W=2,N=4: syms 2,3,1,0, pat=2, mode=0 -> match=0001, any=1, par=1, first=0, count=1, y=3.
REQ-037 syms 1,0,3,2, pat=2, mode=1 -> match=1000, first=3, count=1, y=1 (wrap pair).
REQ-038 syms 2,3,2,3, pat=2, mode=0 -> match=0101, count=2, par=0, first=0, y=3; syms 3,3,3,3, same pat -> match=0000, any=0, y=0.
REQ-039 syms 0,1,2,3, pat=3, mode=0 (succ wraps to 0) -> match=1000, first=3, y=0, any=1; out_ready low 5 cycles -> all outputs unchanged, then IDLE one cycle after handshake.
REQ-040 in_valid toggling during LOAD, start pulsed mid-SCAN -> only accepted symbols stored, start ignored, out_valid exactly N+1 cycles after the 4th accept.
REQ-041 abort in SCAN cycle 2, and separately rst_n low mid-LOAD -> IDLE, busy=0, out_valid=0; next roll-call gives correct results.
